// File: rtl/lcd_ctrl_model.sv
// lcd_ctrl_model: receiving side of an 8-bit HD44780-style parallel LCD bus.
// Captures writer strobes through 2-FF synchronizers, decodes instructions,
// holds a 128-byte DDRAM with address counter and mode flags, and offers a
// registered DDRAM read port for loopback and checking.
module lcd_ctrl_model #(
  parameter int unsigned EXEC_CYCLES  = 2160,
  parameter int unsigned CLEAR_CYCLES = 82080
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  output logic [7:0] lcd_dout,
  output logic       lcd_doe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] ac,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       shift_mode,
  output logic       two_line,
  output logic       font5x10,
  output logic       bus8,
  output logic       protocol_err
);

  localparam int unsigned MAX_CYCLES = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [7:0]       BLANK      = 8'h20;

  typedef enum logic [1:0] {
    ST_INIT_FILL  = 2'd0,
    ST_IDLE       = 2'd1,
    ST_CLEAR_FILL = 2'd2,
    ST_EXEC_WAIT  = 2'd3
  } state_t;

  // Next AC value for one step, honouring the line wrap points of the
  // selected line mode; addresses outside the visible map step modulo 128.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up, input logic two);
    logic [6:0] r;
    if (up) begin
      if (two && (a == 7'h27))       r = 7'h40;
      else if (two && (a == 7'h67))  r = 7'h00;
      else if (!two && (a == 7'h4F)) r = 7'h00;
      else                           r = a + 7'd1;
    end else begin
      if (two && (a == 7'h00))       r = 7'h67;
      else if (two && (a == 7'h40))  r = 7'h27;
      else if (!two && (a == 7'h00)) r = 7'h4F;
      else                           r = a - 7'd1;
    end
    return r;
  endfunction

  // synchronizer bus layout: {en, rs, rw, data[7:0]}
  logic [10:0] sync1_q, sync2_q;
  logic        en_prev_q;
  logic        en_s, rs_s, rw_s, take_s;
  logic [7:0]  data_s;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]      fill_q, fill_d;
  logic [6:0]      ac_q, ac_d;
  logic            disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
  logic            inc_q, inc_d, shift_q, shift_d;
  logic            two_q, two_d, font_q, font_d, bus8_q, bus8_d;
  logic            perr_q, perr_d, busy_q, busy_d;
  logic            doe_q, doe_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      rd_data_q;

  logic [7:0]       mem [128];
  logic             mem_we_s;
  logic [6:0]       mem_waddr_s;
  logic [7:0]       mem_wdata_s;
  logic             wait_load_s;
  logic [CNT_W-1:0] wait_cnt_s;

  assign en_s   = sync2_q[10];
  assign rs_s   = sync2_q[9];
  assign rw_s   = sync2_q[8];
  assign data_s = sync2_q[7:0];
  assign take_s = en_prev_q & ~en_s;

  // Two-stage synchronizer for all bus lines plus the delayed en for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 11'h000;
      sync2_q   <= 11'h000;
      en_prev_q <= 1'b0;
    end else begin
      sync1_q   <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
      sync2_q   <= sync1_q;
      en_prev_q <= sync2_q[10];
    end
  end

  // Next-state, decode, DDRAM write selection and read-back data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    ac_d        = ac_q;
    disp_d      = disp_q;
    cursor_d    = cursor_q;
    blink_d     = blink_q;
    inc_d       = inc_q;
    shift_d     = shift_q;
    two_d       = two_q;
    font_d      = font_q;
    bus8_d      = bus8_q;
    perr_d      = perr_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = ac_q;
    mem_wdata_s = data_s;
    wait_load_s = 1'b0;
    wait_cnt_s  = EXEC_LOAD;

    case (state_q)
      ST_INIT_FILL: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = fill_q;
        mem_wdata_s = BLANK;
        fill_d      = fill_q + 7'd1;
        if (fill_q == 7'h7F) state_d = ST_IDLE;
        else                 state_d = ST_INIT_FILL;
      end
      ST_CLEAR_FILL: begin
        // the busy counter already runs so the total equals CLEAR_CYCLES
        mem_we_s    = 1'b1;
        mem_waddr_s = fill_q;
        mem_wdata_s = BLANK;
        fill_d      = fill_q + 7'd1;
        cnt_d       = cnt_q - CNT_ONE;
        if (fill_q == 7'h7F) begin
          if (cnt_q == CNT_ZERO) state_d = ST_IDLE;
          else                   state_d = ST_EXEC_WAIT;
        end else begin
          state_d = ST_CLEAR_FILL;
        end
      end
      ST_EXEC_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EXEC_WAIT;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_IDLE: state_d = ST_IDLE;
      default: begin
        state_d = ST_INIT_FILL;
        fill_d  = 7'h00;
      end
    endcase

    if (take_s) begin
      if (state_q != ST_IDLE) begin
        // only the busy/AC read is legal while busy
        if (rs_s || !rw_s) perr_d = 1'b1;
        else               perr_d = perr_q;
      end else begin
        case ({rs_s, rw_s})
          2'b00: begin
            casez (data_s)
              8'b1???????: begin ac_d = data_s[6:0]; wait_load_s = 1'b1; end
              8'b01??????: wait_load_s = 1'b1;
              8'b001?????: begin
                bus8_d = data_s[4];
                two_d  = data_s[3];
                font_d = data_s[2];
                wait_load_s = 1'b1;
              end
              8'b0001????: begin
                if (!data_s[3]) ac_d = ac_step(ac_q, data_s[2], two_q);
                else            ac_d = ac_q;
                wait_load_s = 1'b1;
              end
              8'b00001???: begin
                disp_d   = data_s[2];
                cursor_d = data_s[1];
                blink_d  = data_s[0];
                wait_load_s = 1'b1;
              end
              8'b000001??: begin
                inc_d   = data_s[1];
                shift_d = data_s[0];
                wait_load_s = 1'b1;
              end
              8'b0000001?: begin
                ac_d        = 7'h00;
                wait_load_s = 1'b1;
                wait_cnt_s  = CLEAR_LOAD;
              end
              8'b00000001: begin
                ac_d    = 7'h00;
                inc_d   = 1'b1;
                fill_d  = 7'h00;
                cnt_d   = CLEAR_LOAD;
                state_d = ST_CLEAR_FILL;
              end
              default: ac_d = ac_q;
            endcase
          end
          2'b10: begin
            mem_we_s    = 1'b1;
            mem_waddr_s = ac_q;
            mem_wdata_s = data_s;
            ac_d        = ac_step(ac_q, inc_q, two_q);
            wait_load_s = 1'b1;
          end
          2'b11: begin
            ac_d        = ac_step(ac_q, inc_q, two_q);
            wait_load_s = 1'b1;
          end
          default: ac_d = ac_q;
        endcase
      end
    end else begin
      perr_d = perr_q;
    end

    if (wait_load_s) begin
      state_d = ST_EXEC_WAIT;
      cnt_d   = wait_cnt_s;
    end else begin
      cnt_d = cnt_d;
    end

    busy_d = (state_d != ST_IDLE);
    doe_d  = en_s & rw_s;
    if (doe_d) dout_d = rs_s ? mem[ac_q] : {busy_q, ac_q};
    else       dout_d = 8'h00;
  end

  // Control, flag and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT_FILL;
      cnt_q    <= CNT_ZERO;
      fill_q   <= 7'h00;
      ac_q     <= 7'h00;
      disp_q   <= 1'b0;
      cursor_q <= 1'b0;
      blink_q  <= 1'b0;
      inc_q    <= 1'b1;
      shift_q  <= 1'b0;
      two_q    <= 1'b0;
      font_q   <= 1'b0;
      bus8_q   <= 1'b1;
      perr_q   <= 1'b0;
      busy_q   <= 1'b1;
      doe_q    <= 1'b0;
      dout_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      ac_q     <= ac_d;
      disp_q   <= disp_d;
      cursor_q <= cursor_d;
      blink_q  <= blink_d;
      inc_q    <= inc_d;
      shift_q  <= shift_d;
      two_q    <= two_d;
      font_q   <= font_d;
      bus8_q   <= bus8_d;
      perr_q   <= perr_d;
      busy_q   <= busy_d;
      doe_q    <= doe_d;
      dout_q   <= dout_d;
    end
  end

  // DDRAM storage; contents are rebuilt by the fill after reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem[mem_waddr_s] <= mem_wdata_s;
  end

  // Registered read port; a same-cycle write to the same address yields old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= 8'h00;
    else        rd_data_q <= mem[rd_addr];
  end

  assign lcd_dout     = dout_q;
  assign lcd_doe      = doe_q;
  assign rd_data      = rd_data_q;
  assign ac           = ac_q;
  assign busy         = busy_q;
  assign disp_on      = disp_q;
  assign cursor_on    = cursor_q;
  assign blink_on     = blink_q;
  assign inc_mode     = inc_q;
  assign shift_mode   = shift_q;
  assign two_line     = two_q;
  assign font5x10     = font_q;
  assign bus8         = bus8_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_lcd_ctrl_model.sv
// Bench for lcd_ctrl_model: directed test-plan sequences followed by random
// bus traffic, all compared against a behavioural model of the LCD controller.
module tb_lcd_ctrl_model;

  localparam int unsigned EXEC_N  = 20;
  localparam int unsigned CLEAR_N = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [7:0] lcd_dout;
  logic       lcd_doe;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] rd_data;
  logic [6:0] ac;
  logic       busy, disp_on, cursor_on, blink_on, inc_mode, shift_mode;
  logic       two_line, font5x10, bus8, protocol_err;

  lcd_ctrl_model #(.EXEC_CYCLES(EXEC_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .lcd_dout(lcd_dout), .lcd_doe(lcd_doe), .rd_addr(rd_addr),
    .rd_data(rd_data), .ac(ac), .busy(busy), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .inc_mode(inc_mode), .shift_mode(shift_mode), .two_line(two_line),
    .font5x10(font5x10), .bus8(bus8), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [128];
  logic [6:0]  m_ac;
  logic        m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_font, m_bus8, m_perr;
  int unsigned m_bfrom, m_bto;   // busy after edges in [m_bfrom, m_bto)

  logic [7:0]  last_dout;
  logic        last_doe;
  logic [7:0]  rd_hist [1:4];

  function automatic logic m_busy_at(input int unsigned e);
    return (e >= m_bfrom) && (e < m_bto);
  endfunction

  function automatic logic [8:0] m_flags();
    return {m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_font, m_bus8, m_perr};
  endfunction

  function automatic logic [8:0] dut_flags();
    return {disp_on, cursor_on, blink_on, inc_mode, shift_mode, two_line, font5x10, bus8, protocol_err};
  endfunction

  // Display positions form one ring of 80 cells; map address <-> position.
  function automatic logic [6:0] m_step(input logic [6:0] a, input logic up, input logic two);
    int pos;
    int ia;
    ia = int'(a);
    if (two) begin
      if (ia <= 'h27) pos = ia;
      else if (ia >= 'h40 && ia <= 'h67) pos = ia - 'h40 + 40;
      else pos = -1;
    end else begin
      pos = (ia <= 'h4F) ? ia : -1;
    end
    if (pos < 0) return up ? 7'(ia + 1) : 7'(ia + 127);
    pos = (pos + (up ? 1 : 79)) % 80;
    if (two && pos >= 40) return 7'(pos - 40 + 'h40);
    return 7'(pos);
  endfunction

  function automatic void m_reset(input int unsigned e0);
    m_ac = 7'h00;
    {m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_font, m_bus8, m_perr} = 9'b000100010;
    for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
    m_bfrom = 0;
    m_bto   = e0 + 128;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus access: en high 6 cycles, then low with lines held 4 more cycles.
  task automatic access(input logic rs, input logic rw, input logic [7:0] d, input string tag);
    int unsigned f;
    int          k;
    logic [7:0]  exp_dout;
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (4) tick();
    last_doe  = lcd_doe;
    last_dout = lcd_dout;
    check({tag, " doe_en_high"}, 32'(lcd_doe), 32'(rw));
    if (rw) begin
      exp_dout = rs ? m_mem[m_ac] : {m_busy_at(cyc - 1), m_ac};
      check({tag, " dout"}, 32'(lcd_dout), 32'(exp_dout));
    end
    repeat (2) tick();
    lcd_en = 1'b0;
    f = cyc;
    for (int i = 1; i <= 4; i++) begin
      tick();
      rd_hist[i] = rd_data;
    end
    check({tag, " doe_en_low"}, 32'(lcd_doe), 32'd0);
    if (m_busy_at(f + 2) && !(rs == 1'b0 && rw == 1'b1)) begin
      m_perr = 1'b1;
    end else if (rs == 1'b0 && rw == 1'b0 && d != 8'h00) begin
      k = 0;
      for (int i = 0; i < 8; i++) if (d[i]) k = i;
      case (k)
        0: begin for (int i = 0; i < 128; i++) m_mem[i] = 8'h20; m_ac = 7'h00; m_inc = 1'b1; end
        1: m_ac = 7'h00;
        2: begin m_inc = d[1]; m_shift = d[0]; end
        3: begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
        4: if (!d[3]) m_ac = m_step(m_ac, d[2], m_two);
        5: begin m_bus8 = d[4]; m_two = d[3]; m_font = d[2]; end
        7: m_ac = d[6:0];
        default: ;
      endcase
      m_bfrom = f + 3;
      m_bto   = f + 3 + ((k <= 1) ? CLEAR_N : EXEC_N);
    end else if (rs == 1'b1) begin
      if (!rw) m_mem[m_ac] = d;
      m_ac    = m_step(m_ac, m_inc, m_two);
      m_bfrom = f + 3;
      m_bto   = f + 3 + EXEC_N;
    end
  endtask

  task automatic wait_idle();
    while (cyc < m_bto + 1) tick();
  endtask

  task automatic check_mem(input logic [6:0] a, input string tag);
    rd_addr = a;
    tick();
    tick();
    check(tag, 32'(rd_data), 32'(m_mem[a]));
  endtask

  task automatic check_state(input string tag);
    check({tag, " ac"}, 32'(ac), 32'(m_ac));
    check({tag, " flags"}, 32'(dut_flags()), 32'(m_flags()));
    check({tag, " busy"}, 32'(busy), 32'(m_busy_at(cyc)));
  endtask

  // Counts cycles from release until busy first drops; bounded.
  task automatic check_init_busy(input string tag);
    int first_idle;
    logic busy_first;
    first_idle = 0;
    busy_first = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == 1) busy_first = busy;
      if (!busy && first_idle == 0) first_idle = n;
    end
    check({tag, " busy_cycle1"}, 32'(busy_first), 32'd1);
    check({tag, " busy_drop_cycle"}, 32'(first_idle), 32'd128);
  endtask

  initial begin
    int unsigned f;
    logic [7:0] init_seq [7];
    logic [7:0] d;
    int op;

    // ---- reset and initial fill ----
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    m_reset(cyc);
    check_init_busy("init");
    check("init ac", 32'(ac), 32'd0);
    check("init flags", 32'(dut_flags()), 32'h022);
    check("init doe", 32'(lcd_doe), 32'd0);
    check("init dout", 32'(lcd_dout), 32'd0);
    rd_addr = 7'h00; tick(); tick(); check("init rd00", 32'(rd_data), 32'h20);
    rd_addr = 7'h45; tick(); tick(); check("init rd45", 32'(rd_data), 32'h20);
    rd_addr = 7'h7F; tick(); tick(); check("init rd7f", 32'(rd_data), 32'h20);

    // ---- writer-style init sequence ----
    init_seq = '{8'h38, 8'h01, 8'h0C, 8'h06, 8'h80, 8'h52, 8'h56};
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      access(i >= 5, 1'b0, init_seq[i], "init_seq");
    end
    wait_idle();
    check("seq flags", 32'(dut_flags()), 32'h12A);
    check("seq ac", 32'(ac), 32'h02);
    rd_addr = 7'h00; tick(); tick(); check("seq rd00", 32'(rd_data), 32'h52);
    rd_addr = 7'h01; tick(); tick(); check("seq rd01", 32'(rd_data), 32'h56);
    check_state("seq");

    // ---- two-line increment wrap ----
    wait_idle(); access(1'b0, 1'b0, 8'hA7, "wrap_set27");
    wait_idle(); access(1'b1, 1'b0, 8'h58, "wrap_X");
    check("wrap ac40", 32'(ac), 32'h40);
    check_mem(7'h27, "wrap rd27");
    check("wrap rd27 const", 32'(rd_data), 32'h58);
    wait_idle(); access(1'b0, 1'b0, 8'hE7, "wrap_set67");
    wait_idle(); access(1'b1, 1'b0, 8'h59, "wrap_Y");
    check("wrap ac00", 32'(ac), 32'h00);

    // ---- decrement wrap and busy read ----
    wait_idle(); access(1'b0, 1'b0, 8'h04, "dec_entry");
    wait_idle(); access(1'b0, 1'b0, 8'hC0, "dec_set40");
    wait_idle(); access(1'b1, 1'b0, 8'h5A, "dec_Z");
    check("dec ac27", 32'(ac), 32'h27);
    check_mem(7'h40, "dec rd40");
    check("dec rd40 const", 32'(rd_data), 32'h5A);
    wait_idle(); access(1'b0, 1'b1, 8'h00, "busyrd_idle");
    check("busyrd doe", 32'(last_doe), 32'd1);
    check("busyrd dout", 32'(last_dout), 32'h27);

    // ---- access during clear busy ----
    wait_idle(); access(1'b0, 1'b0, 8'h01, "clr");
    f = cyc;
    while (cyc < f + 100) tick();
    access(1'b1, 1'b0, 8'h51, "clr_Q_early");
    check("clr perr", 32'(protocol_err), 32'd1);
    access(1'b0, 1'b1, 8'h00, "clr_busyrd");
    check("clr busyrd bit7", 32'(last_dout[7]), 32'd1);
    wait_idle();
    check_state("clr");
    for (int a = 0; a < 128; a++) check_mem(7'(a), "clr mem");

    // ---- write/read collision on the read port ----
    wait_idle(); access(1'b0, 1'b0, 8'h90, "col_set10");
    rd_addr = 7'h10;
    wait_idle(); access(1'b1, 1'b0, 8'h43, "col_wr");
    check("col old", 32'(rd_hist[3]), 32'h20);
    check("col new", 32'(rd_hist[4]), 32'h43);

    // ---- reset in the middle of a clear fill ----
    wait_idle(); access(1'b0, 1'b0, 8'hFF, "rst_set7f");
    wait_idle(); access(1'b1, 1'b0, 8'h41, "rst_A");
    check_mem(7'h7F, "rst rd7f_A");
    wait_idle(); access(1'b0, 1'b0, 8'h01, "rst_clr");
    f = cyc - 4;
    while (cyc < f + 3 + 59) tick();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    m_reset(cyc);
    check_init_busy("rst");
    check("rst flags", 32'(dut_flags()), 32'h022);
    check("rst ac", 32'(ac), 32'd0);
    rd_addr = 7'h7F; tick(); tick(); check("rst rd7f", 32'(rd_data), 32'h20);

    // ---- random traffic against the model ----
    for (int it = 0; it < 70; it++) begin
      if ($urandom_range(0, 5) != 0) wait_idle();
      op = $urandom_range(0, 9);
      d  = 8'($urandom_range(0, 255));
      if (op <= 3)      access(1'b0, 1'b0, d, "rnd_instr");
      else if (op <= 6) access(1'b1, 1'b0, d, "rnd_wr");
      else if (op == 7) access(1'b1, 1'b1, d, "rnd_rd");
      else              access(1'b0, 1'b1, d, "rnd_busyrd");
      check_state("rnd");
    end
    wait_idle();
    for (int a = 0; a < 128; a++) check_mem(7'(a), "rnd mem");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
